// File: rtl/instr_stream_driver.sv
// Issues single-cycle steps to an 8-bit wrap/reload counter and checks its returned state against a shadow model.
// Latency: first step one cycle after command accept; done pulse two cycles after the last step.
// Backpressure: command ready only while idle; the step interface has no backpressure.
module instr_stream_driver #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    parameter int GAP_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [CNT_W-1:0]  cmd_count_i,
    input  logic [DATA_W-1:0] cmd_seed_i,
    input  logic [GAP_W-1:0]  cmd_gap_i,
    input  logic [DATA_W-1:0] state_in_i,
    output logic              instr_valid_o,
    output logic [DATA_W-1:0] data_in_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              mismatch_o,
    output logic [CNT_W-1:0]  err_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   rem_q;
    logic [DATA_W-1:0]  seed_q;
    logic [GAP_W-1:0]   gap_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic [DATA_W-1:0]  exp_q;
    logic               chk_q;
    logic               mismatch_q;
    logic [CNT_W-1:0]   err_q;
    logic               accept;

    // Ready is forced low during reset so nothing is accepted in that cycle.
    assign cmd_ready_o   = (state_q == S_IDLE) && !reset;
    assign accept        = cmd_valid_i && cmd_ready_o;
    // Step strobe is gated by reset so an in-flight step is cut off immediately.
    assign instr_valid_o = (state_q == S_ISSUE) && !reset;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign data_in_o     = busy_o ? seed_q : '0;
    assign mismatch_o    = mismatch_q;
    assign err_cnt_o     = err_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (cmd_count_i == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (rem_q == CNT_W'(1)) begin
                    state_d = S_DRAIN;
                end else if (gap_q == '0) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                // gap_cnt_q starts at gap_q (>= 1), so this yields exactly gap_q idle cycles.
                if (gap_cnt_q == GAP_W'(1)) begin
                    state_d = S_ISSUE;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Command latch, remaining-step counter, gap timer and shadow counter model.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q     <= '0;
            seed_q    <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            exp_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        rem_q  <= cmd_count_i;
                        seed_q <= cmd_seed_i;
                        gap_q  <= cmd_gap_i;
                        exp_q  <= state_in_i;
                    end
                end
                S_ISSUE: begin
                    rem_q     <= rem_q - CNT_W'(1);
                    gap_cnt_q <= gap_q;
                    exp_q     <= (exp_q == {DATA_W{1'b1}}) ? seed_q : exp_q + DATA_W'(1);
                end
                S_GAP: begin
                    gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Check the returned counter state one cycle after each step; flags clear on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            chk_q      <= 1'b0;
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else begin
            chk_q <= (state_q == S_ISSUE);
            if (accept) begin
                mismatch_q <= 1'b0;
                err_q      <= '0;
            end else if (chk_q && (state_in_i != exp_q)) begin
                mismatch_q <= 1'b1;
                if (err_q != {CNT_W{1'b1}}) begin
                    err_q <= err_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_stream_driver.sv
// Bench for instr_stream_driver: a behavioural counter answers the step interface.
// Table of commands with hand-computed step patterns, plus reset and held-command sequences.
// Each failed check prints one FAIL line; a single summary line ends the run.
module tb_instr_stream_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_count;
    logic [7:0]  cmd_seed;
    logic [3:0]  cmd_gap;
    logic [7:0]  state_in;
    logic        instr_valid;
    logic [7:0]  data_in;
    logic        busy;
    logic        done;
    logic        mismatch;
    logic [15:0] err_cnt;

    instr_stream_driver #(.DATA_W(8), .CNT_W(16), .GAP_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_count_i   (cmd_count),
        .cmd_seed_i    (cmd_seed),
        .cmd_gap_i     (cmd_gap),
        .state_in_i    (state_in),
        .instr_valid_o (instr_valid),
        .data_in_o     (data_in),
        .busy_o        (busy),
        .done_o        (done),
        .mismatch_o    (mismatch),
        .err_cnt_o     (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  init;
        logic [15:0] count;
        logic [7:0]  seed;
        logic [3:0]  gap;
        logic [31:0] corrupt;   // bit k set: returned state is forced to 0x42 on check k
        logic [31:0] exp_mask;  // instr_valid per cycle, bit = cycle index from accept
        int          exp_done;
        int          exp_busy;
        logic [15:0] exp_err;
        logic        exp_mis;
        logic [7:0]  exp_final;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // downstream counter model and per-cycle samples
    logic [7:0]  cnt;
    logic [31:0] corrupt_mask;
    int          issues;
    logic        s_vld, s_rdy, s_busy, s_done, s_mis;
    logic [7:0]  s_din;
    logic [15:0] s_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Sample the current cycle at negedge, then advance one edge and update the counter model.
    task automatic tick();
        @(negedge clk);
        s_vld  = instr_valid;
        s_rdy  = cmd_ready;
        s_busy = busy;
        s_done = done;
        s_mis  = mismatch;
        s_din  = data_in;
        s_err  = err_cnt;
        @(posedge clk);
        #1;
        if (s_vld) begin
            cnt = (cnt == 8'hFF) ? s_din : cnt + 8'd1;
            issues++;
            state_in = (issues < 32 && corrupt_mask[issues]) ? 8'h42 : cnt;
        end else begin
            state_in = cnt;
        end
    endtask

    task automatic start_cmd(input logic [7:0] init, input logic [15:0] count,
                             input logic [7:0] seed, input logic [3:0] gap, input logic [31:0] corrupt);
        cnt          = init;
        state_in     = init;
        issues       = 0;
        corrupt_mask = corrupt;
        cmd_valid    = 1'b1;
        cmd_count    = count;
        cmd_seed     = seed;
        cmd_gap      = gap;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] vmask;
        int          done_cyc;
        int          busy_n;
        logic        din_ok;
        logic        mis_at_done;
        logic [15:0] err_at_done;
        logic        finished;
        vmask = '0; done_cyc = -1; busy_n = 0; din_ok = 1'b1;
        mis_at_done = 1'b0; err_at_done = '0; finished = 1'b0;
        start_cmd(v.init, v.count, v.seed, v.gap, v.corrupt);
        for (int cyc = 0; cyc < 64 && !finished; cyc++) begin
            tick();
            if (cyc == 0) begin
                chk($sformatf("v%0d ready_at_accept", idx), {31'd0, s_rdy}, 32'd1);
                cmd_valid = 1'b0;
            end
            if (s_vld && cyc < 32) vmask[cyc] = 1'b1;
            if (s_busy) begin
                busy_n++;
                if (s_din !== v.seed) din_ok = 1'b0;
            end
            if (done_cyc >= 0) begin
                chk($sformatf("v%0d idle_after_done", idx), {30'd0, s_busy, s_rdy}, 32'd1);
                chk($sformatf("v%0d mismatch_held", idx), {31'd0, s_mis}, {31'd0, v.exp_mis});
                finished = 1'b1;
            end else if (s_done) begin
                done_cyc    = cyc;
                mis_at_done = s_mis;
                err_at_done = s_err;
            end
        end
        if (!finished) begin
            errors++;
            $display("FAIL v%0d timeout: no done_o within 64 cycles", idx);
        end
        chk($sformatf("v%0d valid_pattern", idx), vmask, v.exp_mask);
        chk($sformatf("v%0d done_cycle", idx), done_cyc, v.exp_done);
        chk($sformatf("v%0d busy_cycles", idx), busy_n, v.exp_busy);
        chk($sformatf("v%0d data_in_seed", idx), {31'd0, din_ok}, 32'd1);
        chk($sformatf("v%0d mismatch", idx), {31'd0, mis_at_done}, {31'd0, v.exp_mis});
        chk($sformatf("v%0d err_cnt", idx), {16'd0, err_at_done}, {16'd0, v.exp_err});
        chk($sformatf("v%0d counter_final", idx), {24'd0, cnt}, {24'd0, v.exp_final});
    endtask

    // Reset asserted for one cycle at cycle 'at' of a count=3, gap=2 command.
    task automatic reset_mid(input int at);
        logic any_done;
        logic any_vld;
        start_cmd(8'h00, 16'd3, 8'h05, 4'd2, 32'd0);
        for (int cyc = 0; cyc < at; cyc++) begin
            tick();
            cmd_valid = 1'b0;
        end
        reset = 1'b1;
        tick();
        chk($sformatf("rst@%0d valid_gated", at), {31'd0, s_vld}, 32'd0);
        chk($sformatf("rst@%0d ready_low", at), {31'd0, s_rdy}, 32'd0);
        reset = 1'b0;
        tick();
        chk($sformatf("rst@%0d ready_after", at), {31'd0, s_rdy}, 32'd1);
        chk($sformatf("rst@%0d busy_after", at), {31'd0, s_busy}, 32'd0);
        chk($sformatf("rst@%0d data_in_after", at), {24'd0, s_din}, 32'd0);
        any_done = s_done;
        any_vld  = s_vld;
        for (int k = 0; k < 8; k++) begin
            tick();
            any_done = any_done | s_done;
            any_vld  = any_vld | s_vld;
        end
        chk($sformatf("rst@%0d no_done", at), {31'd0, any_done}, 32'd0);
        chk($sformatf("rst@%0d no_steps", at), {31'd0, any_vld}, 32'd0);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{init:8'hFD, count:16'd4, seed:8'h10, gap:4'd0, corrupt:32'h0,
                    exp_mask:32'h1E, exp_done:6, exp_busy:6, exp_err:16'd0, exp_mis:1'b0, exp_final:8'h11};
        vecs[1] = '{init:8'h00, count:16'd3, seed:8'h55, gap:4'd2, corrupt:32'h0,
                    exp_mask:32'h92, exp_done:9, exp_busy:9, exp_err:16'd0, exp_mis:1'b0, exp_final:8'h03};
        vecs[2] = '{init:8'hFD, count:16'd4, seed:8'h10, gap:4'd0, corrupt:32'h10,
                    exp_mask:32'h1E, exp_done:6, exp_busy:6, exp_err:16'd1, exp_mis:1'b1, exp_final:8'h11};
        vecs[3] = '{init:8'h07, count:16'd0, seed:8'h99, gap:4'd3, corrupt:32'h0,
                    exp_mask:32'h0, exp_done:1, exp_busy:1, exp_err:16'd0, exp_mis:1'b0, exp_final:8'h07};
        vecs[4] = '{init:8'hFE, count:16'd3, seed:8'hA0, gap:4'd1, corrupt:32'h0A,
                    exp_mask:32'h2A, exp_done:7, exp_busy:7, exp_err:16'd2, exp_mis:1'b1, exp_final:8'hA1};

        reset = 1'b1; cmd_valid = 1'b0; cmd_count = '0; cmd_seed = '0; cmd_gap = '0;
        state_in = '0; cnt = '0; corrupt_mask = '0; issues = 0;
        tick();
        tick();
        chk("reset ready", {31'd0, s_rdy}, 32'd0);
        chk("reset outputs", {28'd0, s_vld, s_busy, s_done, s_mis}, 32'd0);
        chk("reset data_err", {s_din, s_err}, 32'd0);
        reset = 1'b0;
        tick();
        chk("ready after release", {31'd0, s_rdy}, 32'd1);

        for (int i = 0; i < 5; i++) begin
            run_vec(i, vecs[i]);
        end

        reset_mid(2);
        reset_mid(4);

        // Command held valid while busy: re-accepted only in the idle cycle after done.
        begin
            logic [31:0] rdy_m, done_m, vld_m;
            rdy_m = '0; done_m = '0; vld_m = '0;
            start_cmd(8'h10, 16'd2, 8'h33, 4'd0, 32'd0);
            for (int cyc = 0; cyc < 12; cyc++) begin
                tick();
                if (s_rdy)  rdy_m[cyc]  = 1'b1;
                if (s_done) done_m[cyc] = 1'b1;
                if (s_vld)  vld_m[cyc]  = 1'b1;
                if (cyc == 5) cmd_valid = 1'b0;
            end
            chk("held ready_pattern", rdy_m, 32'hC21);
            chk("held done_pattern", done_m, 32'h210);
            chk("held valid_pattern", vld_m, 32'hC6);
            chk("held err_cnt", {16'd0, s_err}, 32'd0);
            chk("held counter_final", {24'd0, cnt}, 32'h14);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
